// File: rtl/hazard_detection_unit.sv
// ID/EX data-hazard detector and mul/div sequencer producing the pipeline stall level.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_detection_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int LU_STALL_CYCLES = 1,
    parameter int MD_TIMEOUT      = 64,
    parameter int CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_muldiv,
    input  logic                  flush_ex,
    input  logic                  md_done,
    output logic                  stall_pipeline,
    output logic                  load_use_stall,
    output logic                  muldiv_stall,
    output logic                  md_start,
    output logic                  md_abort,
    output logic                  md_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      load_use_events,
    output logic [CNT_W-1:0]      muldiv_events
);

    localparam int TO_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LU_STALL,
        MD_WAIT,
        RELEASE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [1:0]      lu_cnt;
    logic [TO_W-1:0] md_cnt;
    logic            lu_hit;
    logic            md_hit;
    logic            lu_load;
    logic            set_timeout;

    assign lu_hit = id_valid & ex_valid & ex_mem_read & ~ex_muldiv & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign md_hit = ex_valid & ex_muldiv;

    always_comb begin
        next_state     = state;
        stall_pipeline = 1'b0;
        load_use_stall = 1'b0;
        muldiv_stall   = 1'b0;
        md_start       = 1'b0;
        md_abort       = 1'b0;
        lu_load        = 1'b0;
        set_timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (!flush_ex) begin
                    if (md_hit) begin
                        md_start       = 1'b1;
                        muldiv_stall   = 1'b1;
                        stall_pipeline = 1'b1;
                        next_state     = MD_WAIT;
                    end else if (lu_hit) begin
                        load_use_stall = 1'b1;
                        stall_pipeline = 1'b1;
                        lu_load        = 1'b1;
                        next_state     = (LU_STALL_CYCLES == 1) ? RELEASE : LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                if (flush_ex) begin
                    next_state = IDLE;
                end else begin
                    load_use_stall = 1'b1;
                    stall_pipeline = 1'b1;
                    if (lu_cnt <= 2'd1) begin
                        next_state = RELEASE;
                    end
                end
            end
            MD_WAIT: begin
                // A flush kills the in-flight op even if its result arrives the same cycle.
                if (flush_ex) begin
                    md_abort   = 1'b1;
                    next_state = IDLE;
                end else if (md_done) begin
                    next_state = RELEASE;
                end else if (md_cnt == TO_W'(MD_TIMEOUT)) begin
                    md_abort    = 1'b1;
                    set_timeout = 1'b1;
                    next_state  = IDLE;
                end else begin
                    muldiv_stall   = 1'b1;
                    stall_pipeline = 1'b1;
                end
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (reset) begin
            stall_pipeline = 1'b0;
            load_use_stall = 1'b0;
            muldiv_stall   = 1'b0;
            md_start       = 1'b0;
            md_abort       = 1'b0;
            lu_load        = 1'b0;
            set_timeout    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lu_cnt     <= 2'd0;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            state <= next_state;
            if (lu_load) begin
                lu_cnt <= 2'(LU_STALL_CYCLES - 1);
            end else if (state == LU_STALL && lu_cnt != 2'd0) begin
                lu_cnt <= lu_cnt - 2'd1;
            end
            // md_cnt holds the 1-based index of the current MD_WAIT cycle.
            if (md_start) begin
                md_cnt <= TO_W'(1);
            end else if (state == MD_WAIT && md_cnt != TO_W'(MD_TIMEOUT)) begin
                md_cnt <= md_cnt + TO_W'(1);
            end
            if (set_timeout) begin
                md_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] lu_evt_q;
    logic [CNT_W-1:0] md_evt_q;

    // Saturating counters; a load-use event is only the IDLE-state detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            lu_evt_q    <= '0;
            md_evt_q    <= '0;
        end else begin
            if (stall_pipeline && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (state == IDLE && load_use_stall && lu_evt_q != '1) begin
                lu_evt_q <= lu_evt_q + CNT_W'(1);
            end
            if (md_start && md_evt_q != '1) begin
                md_evt_q <= md_evt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles    = stall_cnt_q;
    assign load_use_events = lu_evt_q;
    assign muldiv_events   = md_evt_q;
`else
    assign stall_cycles    = '0;
    assign load_use_events = '0;
    assign muldiv_events   = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench: instance a uses a 1-cycle load-use bubble, instance b a 3-cycle one.
module tb_hazard_detection_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_muldiv;
    logic        flush_ex;
    logic        md_done;

    logic        a_stall, a_lu_stall, a_md_stall, a_md_start, a_md_abort, a_md_timeout;
    logic [31:0] a_stall_cycles, a_lu_events, a_md_events;
    logic        b_stall, b_lu_stall, b_md_stall, b_md_start, b_md_abort, b_md_timeout;
    logic [31:0] b_stall_cycles, b_lu_events, b_md_events;

    int total;
    int bad;

    hazard_detection_unit #(
        .REG_ADDR_W(5), .LU_STALL_CYCLES(1), .MD_TIMEOUT(8), .CNT_W(32)
    ) u_a (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_muldiv(ex_muldiv), .flush_ex(flush_ex), .md_done(md_done),
        .stall_pipeline(a_stall), .load_use_stall(a_lu_stall), .muldiv_stall(a_md_stall),
        .md_start(a_md_start), .md_abort(a_md_abort), .md_timeout(a_md_timeout),
        .stall_cycles(a_stall_cycles), .load_use_events(a_lu_events), .muldiv_events(a_md_events)
    );

    hazard_detection_unit #(
        .REG_ADDR_W(5), .LU_STALL_CYCLES(3), .MD_TIMEOUT(8), .CNT_W(32)
    ) u_b (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_muldiv(ex_muldiv), .flush_ex(flush_ex), .md_done(md_done),
        .stall_pipeline(b_stall), .load_use_stall(b_lu_stall), .muldiv_stall(b_md_stall),
        .md_start(b_md_start), .md_abort(b_md_abort), .md_timeout(b_md_timeout),
        .stall_cycles(b_stall_cycles), .load_use_events(b_lu_events), .muldiv_events(b_md_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid    = 1'b0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_valid    = 1'b0;
        ex_rd       = 5'd0;
        ex_mem_read = 1'b0;
        ex_muldiv   = 1'b0;
        flush_ex    = 1'b0;
        md_done     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // lw x5 in EX, add x6,x5,x7 in ID
    task automatic drive_load_use();
        id_valid    = 1'b1;
        id_rs1      = 5'd5;
        id_rs2      = 5'd7;
        id_uses_rs1 = 1'b1;
        id_uses_rs2 = 1'b1;
        ex_valid    = 1'b1;
        ex_rd       = 5'd5;
        ex_mem_read = 1'b1;
        ex_muldiv   = 1'b0;
    endtask

    task automatic drive_muldiv();
        ex_valid    = 1'b1;
        ex_muldiv   = 1'b1;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd9;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        drive_muldiv();
        tick();
        #1;
        total++;
        if (a_stall !== 1'b0 || a_md_start !== 1'b0 || a_md_abort !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: stall=%b start=%b abort=%b required 0 0 0", a_stall, a_md_start, a_md_abort);
        end
        total++;
        if (a_md_timeout !== 1'b0 || a_stall_cycles !== 32'd0 || a_lu_events !== 32'd0 || a_md_events !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_regs: timeout=%b stall_cycles=%0d lu=%0d md=%0d required all 0",
                     a_md_timeout, a_stall_cycles, a_lu_events, a_md_events);
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_load_use();
        #1;
        total++;
        if (a_stall !== 1'b1 || a_lu_stall !== 1'b1 || a_md_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_detect: stall=%b lu=%b md=%b required 1 1 0", a_stall, a_lu_stall, a_md_stall);
        end
        tick();
        #1;
        total++;
        if (a_stall !== 1'b0 || a_lu_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_release: stall=%b lu=%b required 0 0", a_stall, a_lu_stall);
        end
        total++;
        if (a_lu_events !== 32'(PERF)) begin
            bad++;
            $display("[TB] FAIL lu_events: got %0d required %0d", a_lu_events, PERF);
        end
        clear_inputs();
        tick();
        #1;
        total++;
        if (a_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_after_release: stall=%b required 0", a_stall);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        drive_load_use();
        ex_rd  = 5'd0;
        id_rs1 = 5'd0;
        #1;
        total++;
        if (a_stall !== 1'b0 || b_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_x0: stall a=%b b=%b required 0 0", a_stall, b_stall);
        end
        ex_rd       = 5'd7;
        id_rs1      = 5'd3;
        id_rs2      = 5'd7;
        id_uses_rs2 = 1'b0;
        #1;
        total++;
        if (a_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_rs2_unused: stall=%b required 0", a_stall);
        end
        id_uses_rs2 = 1'b1;
        #1;
        total++;
        if (a_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lu_rs2_match: stall=%b required 1", a_stall);
        end
        flush_ex = 1'b1;
        #1;
        total++;
        if (a_stall !== 1'b0 || a_lu_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu_flush_idle: stall=%b lu=%b required 0 0", a_stall, a_lu_stall);
        end
        clear_inputs();
    endtask

    task automatic test_lu3_full();
        do_reset();
        drive_load_use();
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (b_stall !== 1'b1 || b_lu_stall !== 1'b1) begin
                bad++;
                $display("[TB] FAIL lu3_stall_cycle%0d: stall=%b lu=%b required 1 1", c, b_stall, b_lu_stall);
            end
            tick();
        end
        #1;
        total++;
        if (b_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lu3_release: stall=%b required 0", b_stall);
        end
        total++;
        if (b_lu_events !== 32'(PERF) || b_stall_cycles !== 32'(3 * PERF)) begin
            bad++;
            $display("[TB] FAIL lu3_counters: lu=%0d stall_cycles=%0d required %0d %0d",
                     b_lu_events, b_stall_cycles, PERF, 3 * PERF);
        end
        clear_inputs();
    endtask

    task automatic test_muldiv();
        do_reset();
        drive_muldiv();
        md_done = 1'b1;
        #1;
        total++;
        if (a_md_start !== 1'b1 || a_stall !== 1'b1 || a_md_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL md_start_cycle: start=%b stall=%b md=%b required 1 1 1", a_md_start, a_stall, a_md_stall);
        end
        tick();
        md_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total++;
            if (a_stall !== 1'b1 || a_md_start !== 1'b0) begin
                bad++;
                $display("[TB] FAIL md_wait%0d: stall=%b start=%b required 1 0", c, a_stall, a_md_start);
            end
            tick();
        end
        md_done = 1'b1;
        #1;
        total++;
        if (a_stall !== 1'b0 || a_md_abort !== 1'b0 || a_md_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL md_done_cycle: stall=%b abort=%b md=%b required 0 0 0", a_stall, a_md_abort, a_md_stall);
        end
        tick();
        md_done = 1'b0;
        #1;
        total++;
        if (a_stall !== 1'b0 || a_md_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL md_release: stall=%b start=%b required 0 0", a_stall, a_md_start);
        end
        total++;
        if (a_md_events !== 32'(PERF) || a_stall_cycles !== 32'(5 * PERF)) begin
            bad++;
            $display("[TB] FAIL md_counters: md=%0d stall_cycles=%0d required %0d %0d",
                     a_md_events, a_stall_cycles, PERF, 5 * PERF);
        end
        clear_inputs();
    endtask

    task automatic test_flush_abort();
        do_reset();
        drive_muldiv();
        tick();
        for (int c = 1; c <= 2; c++) begin
            #1;
            total++;
            if (a_stall !== 1'b1) begin
                bad++;
                $display("[TB] FAIL flush_wait%0d: stall=%b required 1", c, a_stall);
            end
            tick();
        end
        flush_ex = 1'b1;
        #1;
        total++;
        if (a_md_abort !== 1'b1 || a_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_abort: abort=%b stall=%b required 1 0", a_md_abort, a_stall);
        end
        tick();
        flush_ex = 1'b0;
        #1;
        total++;
        if (a_md_start !== 1'b1 || a_md_abort !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_back_idle: start=%b abort=%b required 1 0", a_md_start, a_md_abort);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        drive_muldiv();
        tick();
        ex_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            total++;
            if (a_stall !== 1'b1 || a_md_abort !== 1'b0) begin
                bad++;
                $display("[TB] FAIL timeout_wait%0d: stall=%b abort=%b required 1 0", c, a_stall, a_md_abort);
            end
            tick();
        end
        #1;
        total++;
        if (a_md_abort !== 1'b1 || a_stall !== 1'b0 || a_md_timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_fire: abort=%b stall=%b flag=%b required 1 0 0", a_md_abort, a_stall, a_md_timeout);
        end
        tick();
        tick();
        tick();
        #1;
        total++;
        if (a_md_timeout !== 1'b1 || a_md_abort !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_sticky: flag=%b abort=%b required 1 0", a_md_timeout, a_md_abort);
        end
        do_reset();
        #1;
        total++;
        if (a_md_timeout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_cleared: flag=%b required 0", a_md_timeout);
        end
    endtask

    task automatic test_reset_mid_lu();
        do_reset();
        drive_load_use();
        tick();
        #1;
        total++;
        if (b_stall !== 1'b1 || b_lu_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_lu_stall: stall=%b lu=%b required 1 1", b_stall, b_lu_stall);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        total++;
        if (b_stall !== 1'b0 || b_lu_stall !== 1'b0 || b_md_start !== 1'b0 || b_md_abort !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_lu_reset_out: stall=%b lu=%b start=%b abort=%b required 0",
                     b_stall, b_lu_stall, b_md_start, b_md_abort);
        end
        total++;
        if (b_stall_cycles !== 32'd0 || b_lu_events !== 32'd0 || b_md_events !== 32'd0) begin
            bad++;
            $display("[TB] FAIL mid_lu_reset_cnt: stall_cycles=%0d lu=%0d md=%0d required 0",
                     b_stall_cycles, b_lu_events, b_md_events);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_lu3_full();
        test_muldiv();
        test_flush_abort();
        test_timeout();
        test_reset_mid_lu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
